// File: rtl/dsm_capture.sv
// Captures a fixed window of modulator samples into a buffer, then drains them
// in write order over a valid/ready stream. Single clock domain.
module dsm_capture #(
  parameter  int MOD_BITS = 4,
  parameter  int SAMPLES  = 256,
  localparam int PTR_W    = $clog2(SAMPLES + 1)
) (
  input  logic                internal_clk,
  input  logic                internal_rst_n,
  input  logic [MOD_BITS-1:0] dsm_bit,
  input  logic                dsm_valid,
  input  logic                arm,
  input  logic                trigger,
  input  logic                abort,
  output logic [MOD_BITS-1:0] rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                rd_last,
  output logic                busy,
  output logic [PTR_W-1:0]    fill_count,
  output logic [1:0]          state_dbg
);

  localparam int IDX_W = $clog2(SAMPLES);
  localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(SAMPLES);
  localparam logic [PTR_W-1:0] LAST_CNT = PTR_W'(SAMPLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic                wr_en;
  logic                arm_go;
  logic                last_xfer;
  logic                out_adv;
  logic                rd_adv;
  logic                rd_issue;
  logic                q_valid;
  logic                q_last;
  logic [PTR_W-1:0]    rd_cnt;
  logic [MOD_BITS-1:0] ram_q;
  logic [MOD_BITS-1:0] mem [SAMPLES];

  // Stream handshake: a sample transfers on a rising edge where rd_valid and
  // rd_ready are both 1; while rd_valid=1 and rd_ready=0, rd_data/rd_last hold.
  assign last_xfer = rd_valid && rd_ready && rd_last;
  assign out_adv   = !rd_valid || rd_ready;
  assign rd_adv    = !q_valid || out_adv;
  assign rd_issue  = (state_q == DRAIN) && !abort && rd_adv && (rd_cnt != FULL_CNT);

  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    arm_go  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = ARMED;
          arm_go  = 1'b1;
        end
      end
      ARMED: begin
        if (trigger) begin
          state_d = CAPTURE;
          wr_en   = dsm_valid;
        end
      end
      CAPTURE: wr_en = dsm_valid;
      DRAIN:   if (last_xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (wr_en && (fill_count == LAST_CNT)) state_d = DRAIN;
    if (abort) begin
      state_d = IDLE;
      wr_en   = 1'b0;
      arm_go  = 1'b0;
    end
  end

  always_ff @(posedge internal_clk or negedge internal_rst_n) begin
    if (!internal_rst_n) begin
      state_q    <= IDLE;
      fill_count <= '0;
    end else begin
      state_q <= state_d;
      if (arm_go)     fill_count <= '0;
      else if (wr_en) fill_count <= fill_count + 1'b1;
    end
  end

  // Buffer has no reset so it maps onto block RAM; the read register only
  // advances when the prefetch stage can move, giving stall-safe reads.
  always_ff @(posedge internal_clk) begin
    if (wr_en)    mem[fill_count[IDX_W-1:0]] <= dsm_bit;
    if (rd_issue) ram_q <= mem[rd_cnt[IDX_W-1:0]];
  end

  // Two-stage drain: RAM read stage (q_*) feeding the output register (rd_*).
  always_ff @(posedge internal_clk or negedge internal_rst_n) begin
    if (!internal_rst_n) begin
      rd_cnt   <= '0;
      q_valid  <= 1'b0;
      q_last   <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
    end else if (abort || state_q != DRAIN) begin
      rd_cnt   <= '0;
      q_valid  <= 1'b0;
      q_last   <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      if (rd_adv) begin
        q_valid <= rd_issue;
        q_last  <= (rd_cnt == LAST_CNT);
        if (rd_issue) rd_cnt <= rd_cnt + 1'b1;
      end
      if (out_adv) begin
        rd_valid <= q_valid;
        rd_last  <= q_valid && q_last;
        if (q_valid) rd_data <= ram_q;
      end
    end
  end

endmodule
